sa_weight_load_stage: RTL

//  Receiving end of the systolic-array issue interface: WL (weight-load) stage front-end.

---
 rtl/sa_weight_load_stage.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/sa_weight_load_stage.sv
// -----------------------------------------------------------------------------
// sa_weight_load_stage
//   Weight-load (WL) stage front-end of the systolic array. Accepts one opaque
//   instruction per start pulse, fetches MESH_WIDTH weight rows from the matrix
//   register file (one outstanding read at a time, rows 0..MESH_WIDTH-1 in
//   order), writes each row into the array weight registers in the cycle its
//   data returns, then offers the instruction to the compute stage.
//
//   Ports
//     clk_i, rst_ni            clock, asynchronous active-low reset
//     wl_ready_o               stage idle, start_i will be taken
//     start_i, instr_i         issue pulse and instruction
//     rd_req_o, rd_row_o       row read request / row index (held until grant)
//     rd_gnt_i                 read request accepted
//     rd_valid_i, rd_data_i    read data return
//     w_we_o, w_row_o, w_data_o weight-row write into the array
//     ex_valid_o, ex_instr_o   loaded instruction for the compute stage
//     ex_ready_i               compute stage accepts
//
//   Also contains sa_weight_load_stage_chk, a protocol monitor that counts
//   illegal issue pulses and flags unstable request / hand-off outputs.
// -----------------------------------------------------------------------------

package matrix_cps_pkg;
    typedef logic [31:0] sa_instr_t;
endpackage

module sa_weight_load_stage #(
    parameter int unsigned  MESH_WIDTH = 32'd4,
    parameter int unsigned  DATA_WIDTH = 32'd32,
    parameter type          instr_t    = matrix_cps_pkg::sa_instr_t,
    localparam int unsigned RW         = (MESH_WIDTH > 32'd1) ? $clog2(MESH_WIDTH) : 32'd1,
    localparam int unsigned ROW_W      = MESH_WIDTH * DATA_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic             wl_ready_o,
    input  logic             start_i,
    input  instr_t           instr_i,
    output logic             rd_req_o,
    output logic [RW-1:0]    rd_row_o,
    input  logic             rd_gnt_i,
    input  logic             rd_valid_i,
    input  logic [ROW_W-1:0] rd_data_i,
    output logic             w_we_o,
    output logic [RW-1:0]    w_row_o,
    output logic [ROW_W-1:0] w_data_o,
    output logic             ex_valid_o,
    output instr_t           ex_instr_o,
    input  logic             ex_ready_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HAND = 2'd3
    } state_e;

    localparam logic [RW-1:0] LAST_ROW = RW'(MESH_WIDTH - 32'd1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(32'd1);

    state_e        state_q, state_d;
    logic [RW-1:0] cnt_q, cnt_d;
    instr_t        instr_q, instr_d;

    // State, row counter and latched instruction registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
        end
    end

    // Next-state logic and state-decoded outputs. Data-path outputs are forced
    // to zero outside their active state so nothing stale leaks to the array.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        instr_d    = instr_q;
        wl_ready_o = 1'b0;
        rd_req_o   = 1'b0;
        rd_row_o   = '0;
        w_we_o     = 1'b0;
        w_row_o    = '0;
        w_data_o   = '0;
        ex_valid_o = 1'b0;
        ex_instr_o = '0;

        case (state_q)
            ST_IDLE: begin
                wl_ready_o = 1'b1;
                if (start_i) begin
                    instr_d = instr_i;
                    cnt_d   = '0;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            // A data beat arriving together with the grant is not taken here;
            // only the grant advances the FSM.
            ST_REQ: begin
                rd_req_o = 1'b1;
                rd_row_o = cnt_q;
                if (rd_gnt_i) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end

            ST_WAIT: begin
                if (rd_valid_i) begin
                    w_we_o   = 1'b1;
                    w_row_o  = cnt_q;
                    w_data_o = rd_data_i;
                    if (cnt_q == LAST_ROW) begin
                        state_d = ST_HAND;
                    end else begin
                        cnt_d   = cnt_q + ROW_ONE;
                        state_d = ST_REQ;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end

            ST_HAND: begin
                ex_valid_o = 1'b1;
                ex_instr_o = instr_q;
                if (ex_ready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HAND;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// -----------------------------------------------------------------------------
// sa_weight_load_stage_chk
//   Protocol monitor for sa_weight_load_stage, instantiated alongside it.
//     start_viol_cnt_o  saturating count of start_i pulses while wl_ready_i=0
//     req_viol_o        sticky: rd_req/rd_row changed before grant
//     ex_viol_o         sticky: ex_valid dropped or ex_instr changed before ready
// -----------------------------------------------------------------------------
module sa_weight_load_stage_chk #(
    parameter int unsigned RW      = 32'd2,
    parameter type         instr_t = matrix_cps_pkg::sa_instr_t
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wl_ready_i,
    input  logic          start_i,
    input  logic          rd_req_i,
    input  logic [RW-1:0] rd_row_i,
    input  logic          rd_gnt_i,
    input  logic          ex_valid_i,
    input  instr_t        ex_instr_i,
    input  logic          ex_ready_i,
    output logic [7:0]    start_viol_cnt_o,
    output logic          req_viol_o,
    output logic          ex_viol_o
);

    logic [7:0]    cnt_q, cnt_d;
    logic          req_viol_q, req_viol_d;
    logic          ex_viol_q, ex_viol_d;
    logic          req_pend_q, req_pend_d;
    logic [RW-1:0] row_q, row_d;
    logic          ex_pend_q, ex_pend_d;
    instr_t        ex_instr_q, ex_instr_d;

    // Monitor state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= 8'd0;
            req_viol_q <= 1'b0;
            ex_viol_q  <= 1'b0;
            req_pend_q <= 1'b0;
            row_q      <= '0;
            ex_pend_q  <= 1'b0;
            ex_instr_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            req_viol_q <= req_viol_d;
            ex_viol_q  <= ex_viol_d;
            req_pend_q <= req_pend_d;
            row_q      <= row_d;
            ex_pend_q  <= ex_pend_d;
            ex_instr_q <= ex_instr_d;
        end
    end

    // Violation detection against the previous cycle's pending handshakes
    always_comb begin
        cnt_d      = cnt_q;
        req_viol_d = req_viol_q;
        ex_viol_d  = ex_viol_q;
        if (start_i && !wl_ready_i && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
        if (req_pend_q && (!rd_req_i || (rd_row_i != row_q))) begin
            req_viol_d = 1'b1;
        end else begin
            req_viol_d = req_viol_q;
        end
        if (ex_pend_q && (!ex_valid_i || (ex_instr_i != ex_instr_q))) begin
            ex_viol_d = 1'b1;
        end else begin
            ex_viol_d = ex_viol_q;
        end
        req_pend_d = rd_req_i & ~rd_gnt_i;
        row_d      = rd_row_i;
        ex_pend_d  = ex_valid_i & ~ex_ready_i;
        ex_instr_d = ex_instr_i;
    end

    assign start_viol_cnt_o = cnt_q;
    assign req_viol_o       = req_viol_q;
    assign ex_viol_o        = ex_viol_q;

endmodule
